// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: locks one producer for a burst of up to MAX_BURST
// beats and steers its data onto a shared FIFO write port, stalling while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           found;
  logic [IDW-1:0] win;

  // Rotating search starting just after the previous owner gives round-robin fairness.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    gnt        = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          owner_d = win;
          cnt_d   = '0;
        end
      end
      BURST: begin
        busy       = 1'b1;
        fifo_wr_en = req[owner_q] && !fifo_full;
        if (fifo_wr_en) begin
          gnt[owner_q] = 1'b1;
          fifo_din     = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
          if (req_last[owner_q] || cnt_q == CW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!req[owner_q]) begin
          // Owner walked away mid-burst; a full FIFO alone keeps the lock.
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: producer queues feed the DUT and a
// scoreboard of expected FIFO writes is checked on every write cycle.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_last, gnt;
  logic [N*DW-1:0] req_data;
  logic          fifo_full, fifo_wr_en, busy;
  logic [DW-1:0] fifo_din;
  logic [1:0]    owner_id;

  logic [8:0]    pq [N][$];
  logic [7:0]    exp_q [$];
  logic [7:0]    sb_e;
  logic [N-1:0]  hold, acc;
  logic          model_fifo;
  int            fcnt;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .fifo_full(fifo_full), .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .owner_id(owner_id), .busy(busy)
  );

  // Scoreboard and invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if ((gnt & (gnt - 1'b1)) != 0 || fifo_wr_en !== |gnt || (fifo_wr_en && fifo_full)) begin
        n_bad++;
        $display("FAIL invariant gnt=%b wr_en=%b full=%b", gnt, fifo_wr_en, fifo_full);
      end
      if (fifo_wr_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_write din=%h expected none", fifo_din);
        end else begin
          sb_e = exp_q.pop_front();
          if (fifo_din !== sb_e) begin
            n_bad++;
            $display("FAIL sb_data din=%h expected %h", fifo_din, sb_e);
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && !hold[i]) begin
        req[i]             = 1'b1;
        req_last[i]        = pq[i][0][8];
        req_data[i*DW +: DW] = pq[i][0][7:0];
      end else begin
        req[i]             = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    acc = req & gnt;
    if (fifo_wr_en) fcnt++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) void'(pq[i].pop_front());
    acc = '0;
    if (model_fifo) fifo_full = (fcnt >= 16);
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    hold = '0; acc = '0; fifo_full = 1'b0; model_fifo = 1'b0; fcnt = 0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; hold = '0; acc = '0; model_fifo = 1'b0; fcnt = 0;
    req = '1; req_last = '0; req_data = 32'hA5A5A5A5; fifo_full = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (gnt !== 4'b0)        begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_din !== 8'h00)  begin n_bad++; $display("FAIL reset_din got %h want 00", fifo_din); end
    n_cmp++; if (owner_id !== 2'd0)   begin n_bad++; $display("FAIL reset_owner got %0d want 0", owner_id); end
    do_reset();
  endtask

  task automatic test_single();
    logic eb;
    do_reset();
    pq[2].push_back(9'h011); pq[2].push_back(9'h022); pq[2].push_back(9'h133);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    drive();
    for (int c = 0; c < 5; c++) begin
      at_neg();
      eb = (c >= 1 && c <= 3);
      n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL single_busy c=%0d got %b want %b", c, busy, eb); end
      n_cmp++; if (gnt !== (eb ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL single_gnt c=%0d got %b want %b", c, gnt, eb ? 4'b0100 : 4'b0000); end
      if (eb) begin
        n_cmp++; if (owner_id !== 2'd2) begin n_bad++; $display("FAIL single_owner c=%0d got %0d want 2", c, owner_id); end
      end
      adv();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL single_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [3:0] tg [0:10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    do_reset();
    pq[0].push_back(9'h101); pq[0].push_back(9'h102);
    pq[1].push_back(9'h111); pq[2].push_back(9'h121); pq[3].push_back(9'h131);
    exp_q.push_back(8'h01); exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    exp_q.push_back(8'h31); exp_q.push_back(8'h02);
    drive();
    for (int c = 0; c < 11; c++) begin
      at_neg();
      n_cmp++; if (gnt !== tg[c]) begin n_bad++; $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt, tg[c]); end
      n_cmp++; if (busy !== |tg[c]) begin n_bad++; $display("FAIL rr_busy c=%0d got %b want %b", c, busy, |tg[c]); end
      adv();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_burst_cap();
    logic [3:0] tg [0:14] = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 2, 0, 2, 2, 0, 0};
    logic       tb [0:14] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      pq[1].push_back({1'b0, 8'(8'h40 + k)});
      exp_q.push_back(8'(8'h40 + k));
    end
    drive();
    for (int c = 0; c < 15; c++) begin
      at_neg();
      n_cmp++; if (gnt !== tg[c]) begin n_bad++; $display("FAIL cap_gnt c=%0d got %b want %b", c, gnt, tg[c]); end
      n_cmp++; if (busy !== tb[c]) begin n_bad++; $display("FAIL cap_busy c=%0d got %b want %b", c, busy, tb[c]); end
      adv();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL cap_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [3:0] tg [0:11] = '{0, 8, 8, 0, 0, 0, 8, 8, 0, 8, 8, 0};
    logic       tb [0:11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pq[3].push_back({(k == 5), 8'(8'h60 + k)});
      exp_q.push_back(8'(8'h60 + k));
    end
    drive();
    for (int c = 0; c < 12; c++) begin
      at_neg();
      n_cmp++; if (gnt !== tg[c]) begin n_bad++; $display("FAIL bp_gnt c=%0d got %b want %b", c, gnt, tg[c]); end
      n_cmp++; if (busy !== tb[c]) begin n_bad++; $display("FAIL bp_busy c=%0d got %b want %b", c, busy, tb[c]); end
      if (tb[c]) begin
        n_cmp++; if (owner_id !== 2'd3) begin n_bad++; $display("FAIL bp_owner c=%0d got %0d want 3", c, owner_id); end
      end
      adv();
      fifo_full = (c + 1 >= 3 && c + 1 <= 5);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_fifo_fill();
    do_reset();
    model_fifo = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pq[0].push_back({1'b0, 8'(8'h80 + k)});
      if (k < 16) exp_q.push_back(8'(8'h80 + k));
    end
    drive();
    for (int c = 0; c < 40; c++) begin
      at_neg();
      adv();
    end
    n_cmp++; if (fcnt != 16) begin n_bad++; $display("FAIL fill_writes got %0d want 16", fcnt); end
    n_cmp++; if (pq[0].size() != 4) begin n_bad++; $display("FAIL fill_left got %0d want 4", pq[0].size()); end
    n_cmp++; if (busy !== 1'b1 || gnt !== 4'b0) begin n_bad++; $display("FAIL fill_stall got busy=%b gnt=%b want busy=1 gnt=0000", busy, gnt); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fill_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_abandon();
    logic [3:0] tg [0:9] = '{0, 1, 0, 0, 4, 0, 1, 1, 0, 0};
    logic       tb [0:9] = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 0};
    do_reset();
    pq[0].push_back(9'h0A0); pq[0].push_back(9'h0A1); pq[0].push_back(9'h0A2);
    pq[2].push_back(9'h1C0);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hC0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    drive();
    for (int c = 0; c < 10; c++) begin
      at_neg();
      n_cmp++; if (gnt !== tg[c]) begin n_bad++; $display("FAIL abandon_gnt c=%0d got %b want %b", c, gnt, tg[c]); end
      n_cmp++; if (busy !== tb[c]) begin n_bad++; $display("FAIL abandon_busy c=%0d got %b want %b", c, busy, tb[c]); end
      if (c == 4) begin
        n_cmp++; if (owner_id !== 2'd2) begin n_bad++; $display("FAIL abandon_owner got %0d want 2", owner_id); end
      end
      if (c == 1) hold[0] = 1'b1;
      if (c == 2) hold[0] = 1'b0;
      adv();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL abandon_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [3:0] tg [0:4] = '{0, 1, 0, 8, 0};
    do_reset();
    for (int k = 0; k < 4; k++) pq[1].push_back({1'b0, 8'(8'h50 + k)});
    exp_q.push_back(8'h50);
    drive();
    at_neg();
    adv();
    at_neg();
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL areset_pre_gnt got %b want 0010", gnt); end
    adv();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL areset_busy got %b want 0", busy); end
    n_cmp++; if (gnt !== 4'b0)        begin n_bad++; $display("FAIL areset_gnt got %b want 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL areset_wr_en got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_din !== 8'h00)  begin n_bad++; $display("FAIL areset_din got %h want 00", fifo_din); end
    pq[1].delete();
    pq[0].push_back(9'h1D0); pq[3].push_back(9'h1D3);
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      at_neg();
      n_cmp++; if (gnt !== tg[c]) begin n_bad++; $display("FAIL areset_post_gnt c=%0d got %b want %b", c, gnt, tg[c]); end
      adv();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL areset_drain got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_fifo_fill();
    test_abandon();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one simple_fifo write port among NUM_REQ producers.
- Locks a granted producer for a burst of up to MAX_BURST beats, muxes its data onto the FIFO write port, and never writes while the FIFO reports full.
- Sits between producer blocks and the FIFO's wr_en/din/full pins.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8)
- DATA_WIDTH, 8, data width; must match the FIFO
- MAX_BURST, 4, maximum beats per grant (1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- req  input  NUM_REQ  per-producer request; bit i high = producer i has a beat on req_data slice i
- req_last  input  NUM_REQ  per-producer last-beat marker, sampled with req
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_full  input  1  FIFO full flag
- gnt  output  NUM_REQ  one-hot beat accept; a beat from producer i transfers when req[i] && gnt[i]
- fifo_wr_en  output  1  FIFO write enable
- fifo_din  output  DATA_WIDTH  FIFO write data
- owner_id  output  clog2(NUM_REQ)  index of the locked producer, valid when busy
- busy  output  1  high while a burst is locked

Behaviour:
- States:
  - IDLE: no lock.
  - BURST: owner locked.
- Reset (rst=0, async):
  - state=IDLE, owner_id=0, beat_cnt=0.
  - last_owner=NUM_REQ-1, so producer 0 has first priority.
  - busy=0, gnt=0, fifo_wr_en=0.
  - fifo_din=0 whenever not writing.
- IDLE:
  - If |req, pick the first set bit scanning last_owner+1, last_owner+2, ... with modulo wrap.
  - Next edge: state=BURST, owner_id=winner, beat_cnt=0.
  - The arbitration cycle issues no grant; exactly one bubble per burst.
  - fifo_full does not block arbitration.
- BURST (combinational outputs):
  - fifo_wr_en = req[owner_id] && !fifo_full.
  - gnt = one-hot(owner_id) when fifo_wr_en, else 0.
  - fifo_din = req_data slice owner_id when fifo_wr_en, else 0.
  - Zero-latency path: the FIFO captures the beat on the same edge the producer sees gnt.
- Beat accepted: beat_cnt increments.
- Burst ends, and the next edge goes to IDLE with last_owner=owner_id, when either:
  - an accepted beat has req_last[owner_id]=1, or
  - the accepted beat is number MAX_BURST (beat_cnt==MAX_BURST-1).
- Owner drops req mid-burst (req[owner_id]=0 in BURST, no beat):
  - Lock released; next edge goes to IDLE, last_owner=owner_id.
  - No write occurs.
- fifo_full=1 in BURST:
  - gnt=0, fifo_wr_en=0.
  - Lock, beat_cnt and state all held; no timeout.
- Non-owner req bits are ignored in BURST. Their gnt bits stay 0, and they must hold data until granted.
- busy=1 exactly in BURST; owner_id holds its value in IDLE.
- Reset asserted mid-burst:
  - Immediate return to IDLE; outputs go to reset values asynchronously.
  - The partially written burst is not rolled back.
- beat_cnt width is clog2(MAX_BURST+1) and never exceeds MAX_BURST-1 in BURST.
- Invariants:
  - gnt is one-hot or zero.
  - fifo_wr_en = |gnt.
  - fifo_wr_en is never 1 while fifo_full=1.

Test Plan:
- Reset then single requester: req=4'b0100, req_last pulsed on beat 3, data 0x11,0x22,0x33 -> 1 idle cycle, then owner_id=2, three fifo_wr_en pulses with din 0x11,0x22,0x33, busy drops after the third beat.
- Round-robin fairness: req=4'b1111 held, req_last=1 on every beat, MAX_BURST=4 -> grant order 0,1,2,3,0, one beat each, one bubble cycle between grants.
- Burst cap: producer 1 streams 10 beats with no req_last, MAX_BURST=4 -> exactly 4 writes, release, re-arbitrate; with others idle, producer 1 regains the lock after one bubble.
- Backpressure: fifo_full forced 1 for 3 cycles mid-burst of producer 3 -> gnt=0 and fifo_wr_en=0 for those cycles, owner_id stays 3, beat_cnt unchanged, stream resumes with no lost or duplicated data. End-to-end with simple_fifo (depth 16): 20 beats offered -> exactly 16 written before full.
- Owner abandon: producer 0 locked, deasserts req after 1 beat -> next cycle IDLE; next pending requester (2) wins with priority from 1.
- Async reset mid-burst: rst low between clock edges -> busy, gnt and fifo_wr_en go 0 without a clock edge; after release, req=4'b1001 -> producer 0 wins first.
